// File: rtl/stream_demux2.sv
// ---------------------------------------------------------------------------
// stream_demux2
//
// Registered 1-to-2 stream demultiplexer. Each word on the single
// valid/ready input stream is routed to port A or port B and parked in that
// port's one-entry holding register until the consumer takes it. Because the
// two holding registers are independent, a stalled port never blocks a word
// that is already buffered on the other port. Routing follows in_sel
// (0 -> A, 1 -> B), or an internal alternating pointer when alt_mode=1.
//
// Ports:
//   clk       - clock, rising edge active
//   rst       - asynchronous active-high reset
//   in_data   - input word
//   in_sel    - destination select (0 = A, 1 = B), ignored in alt mode
//   in_valid  - input word valid
//   in_ready  - block accepts the word this cycle (combinational)
//   alt_mode  - 1 = alternate destinations A,B,A,B... starting at A
//   a_data    - port A word
//   a_valid   - port A holding register full
//   a_ready   - port A consumer accepts
//   b_data    - port B word
//   b_valid   - port B holding register full
//   b_ready   - port B consumer accepts
//   cnt_a     - saturating count of words accepted for A
//   cnt_b     - saturating count of words accepted for B
// ---------------------------------------------------------------------------
module stream_demux2 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             alt_mode,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             a_valid_q, a_valid_d;
  logic [WIDTH-1:0] a_data_q,  a_data_d;
  logic             b_valid_q, b_valid_d;
  logic [WIDTH-1:0] b_data_q,  b_data_d;
  logic             ptr_q,     ptr_d;
  logic [CNT_W-1:0] cnt_a_q,   cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q,   cnt_b_d;

  logic dest;
  logic accept;
  logic load_a;
  logic load_b;

  // Destination and handshake. in_ready only looks at the destination port:
  // a full, non-draining destination stalls the stream even if the other
  // port is empty, so words are never reordered.
  always_comb begin
    dest     = alt_mode ? ptr_q : in_sel;
    in_ready = dest ? (!b_valid_q || b_ready) : (!a_valid_q || a_ready);
    accept   = in_valid && in_ready;
    load_a   = accept && !dest;
    load_b   = accept &&  dest;
  end

  // Holding registers. A load has priority over a drain on the same port,
  // which gives one word per cycle per port when the consumer keeps up.
  // Data is only written on a load, so it stays put after a drain.
  always_comb begin
    a_valid_d = a_valid_q;
    a_data_d  = a_data_q;
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;

    if (load_a) begin
      a_valid_d = 1'b1;
      a_data_d  = in_data;
    end else if (a_valid_q && a_ready) begin
      a_valid_d = 1'b0;
    end

    if (load_b) begin
      b_valid_d = 1'b1;
      b_data_d  = in_data;
    end else if (b_valid_q && b_ready) begin
      b_valid_d = 1'b0;
    end
  end

  // Alternating pointer. Leaving alt mode for even a single cycle parks the
  // pointer at A, so every alt-mode burst starts on port A.
  always_comb begin
    ptr_d = ptr_q;
    if (!alt_mode) begin
      ptr_d = 1'b0;
    end else if (accept) begin
      ptr_d = !ptr_q;
    end
  end

  // Per-port transfer counters, holding at all-ones instead of wrapping.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (load_a && (cnt_a_q != CNT_MAX)) begin
      cnt_a_d = cnt_a_q + CNT_ONE;
    end
    if (load_b && (cnt_b_q != CNT_MAX)) begin
      cnt_b_d = cnt_b_q + CNT_ONE;
    end
  end

  // State registers; reset throws away anything buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      ptr_q     <= 1'b0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_data_q  <= a_data_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
      ptr_q     <= ptr_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
    end
  end

  always_comb begin
    a_valid = a_valid_q;
    a_data  = a_data_q;
    b_valid = b_valid_q;
    b_data  = b_data_q;
    cnt_a   = cnt_a_q;
    cnt_b   = cnt_b_q;
  end

endmodule

// File: tb/tb_stream_demux2.sv
// ---------------------------------------------------------------------------
// tb_stream_demux2
//
// Testbench for stream_demux2 (WIDTH=8, CNT_W=3 so counter saturation is
// reached quickly). A reference model holds one queue per output port plus
// the routing pointer and transfer counts; on every falling edge the monitor
// compares the DUT against the model and then advances the model by the
// transfers the coming rising edge will perform.
// ---------------------------------------------------------------------------
module tb_stream_demux2;

   localparam int WIDTH   = 8;
   localparam int CNT_W   = 3;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             in_valid;
   logic             in_ready;
   logic             alt_mode;
   logic [WIDTH-1:0] a_data;
   logic             a_valid;
   logic             a_ready;
   logic [WIDTH-1:0] b_data;
   logic             b_valid;
   logic             b_ready;
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] expA[$];
   logic [WIDTH-1:0] expB[$];
   logic [WIDTH-1:0] mLastA;
   logic [WIDTH-1:0] mLastB;
   int               mCntA;
   int               mCntB;
   bit               mPtr;
   bit               mStalled;

   stream_demux2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .alt_mode (alt_mode),
      .a_data   (a_data),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .b_data   (b_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .cnt_a    (cnt_a),
      .cnt_b    (cnt_b)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs shortly after the rising edge
   task automatic applyStimulus(input bit v, input logic [WIDTH-1:0] d, input bit s,
                                input bit alt, input bit ar, input bit br);
      @(posedge clk);
      #2;
      in_valid = v;
      in_data  = d;
      in_sel   = s;
      alt_mode = alt;
      a_ready  = ar;
      b_ready  = br;
   endtask

   task automatic clearModel();
      expA.delete();
      expB.delete();
      mLastA   = '0;
      mLastB   = '0;
      mCntA    = 0;
      mCntB    = 0;
      mPtr     = 1'b0;
      mStalled = 1'b0;
   endtask

   // Assert reset between edges, confirm it takes effect without a clock,
   // then release it a cycle later
   task automatic doReset();
      @(posedge clk);
      #3;
      in_valid = 1'b0;
      a_ready  = 1'b0;
      b_ready  = 1'b0;
      rst      = 1'b1;
      #1;
      checkOutput("async_rst_a_valid", 32'(a_valid), 32'd0);
      checkOutput("async_rst_b_valid", 32'(b_valid), 32'd0);
      checkOutput("async_rst_a_data",  32'(a_data),  32'd0);
      checkOutput("async_rst_b_data",  32'(b_data),  32'd0);
      checkOutput("async_rst_cnt_a",   32'(cnt_a),   32'd0);
      checkOutput("async_rst_cnt_b",   32'(cnt_b),   32'd0);
      clearModel();
      @(posedge clk);
      #3;
      rst = 1'b0;
   endtask

   // Monitor: compare DUT against the model, then apply the coming edge's
   // drains and accepts to the model
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         bit dst;
         bit rdy;
         checkOutput("a_valid", 32'(a_valid), 32'(expA.size() != 0));
         checkOutput("b_valid", 32'(b_valid), 32'(expB.size() != 0));
         checkOutput("a_data",  32'(a_data),  32'(mLastA));
         checkOutput("b_data",  32'(b_data),  32'(mLastB));
         checkOutput("cnt_a",   32'(cnt_a),   32'(mCntA));
         checkOutput("cnt_b",   32'(cnt_b),   32'(mCntB));

         dst = alt_mode ? mPtr : in_sel;
         rdy = dst ? (expB.size() == 0 || b_ready) : (expA.size() == 0 || a_ready);
         checkOutput("in_ready", 32'(in_ready), 32'(rdy));

         if (expA.size() != 0 && a_ready) void'(expA.pop_front());
         if (expB.size() != 0 && b_ready) void'(expB.pop_front());

         if (in_valid && rdy) begin
            if (dst) begin
               expB.push_back(in_data);
               mLastB = in_data;
               if (mCntB < CNT_MAX) mCntB++;
            end else begin
               expA.push_back(in_data);
               mLastA = in_data;
               if (mCntA < CNT_MAX) mCntA++;
            end
            if (alt_mode) mPtr = !mPtr;
         end
         if (!alt_mode) mPtr = 1'b0;
         mStalled = in_valid && !rdy;
      end
   end

   initial begin
      bit altCur;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_sel   = 1'b0;
      alt_mode = 1'b0;
      a_ready  = 1'b0;
      b_ready  = 1'b0;
      clearModel();
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_a_valid", 32'(a_valid), 32'd0);
      checkOutput("rst_b_valid", 32'(b_valid), 32'd0);
      checkOutput("rst_cnt_a",   32'(cnt_a),   32'd0);
      @(posedge clk);
      #3 rst = 1'b0;

      // Single word to a stalled A port, then a second A word must wait
      applyStimulus(1, 8'h5A, 0, 0, 0, 0);
      applyStimulus(1, 8'h77, 0, 0, 0, 0);
      #1;
      checkOutput("t1_a_valid",  32'(a_valid),  32'd1);
      checkOutput("t1_a_data",   32'(a_data),   32'h5A);
      checkOutput("t1_b_valid",  32'(b_valid),  32'd0);
      checkOutput("t1_cnt_a",    32'(cnt_a),    32'd1);
      checkOutput("t1_in_ready", 32'(in_ready), 32'd0);

      // A full and stalled; a B word still goes straight through
      doReset();
      applyStimulus(1, 8'h11, 0, 0, 0, 0);
      applyStimulus(1, 8'h22, 1, 0, 0, 0);
      #1;
      checkOutput("t3_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(0, 8'h00, 0, 0, 0, 1);
      #1;
      checkOutput("t3_a_data_held", 32'(a_data), 32'h11);
      checkOutput("t3_b_data",      32'(b_data), 32'h22);
      applyStimulus(0, 8'h00, 0, 0, 0, 1);
      applyStimulus(0, 8'h00, 0, 0, 1, 1);
      #1;
      checkOutput("t3_a_data_stall", 32'(a_data), 32'h11);

      // Back-to-back stream to B at full rate
      doReset();
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1, 8'(i), 1, 0, 0, 1);
         #1;
         checkOutput("t2_in_ready", 32'(in_ready), 32'd1);
      end
      applyStimulus(0, 8'h00, 0, 0, 0, 1);
      #1;
      checkOutput("t2_b_data", 32'(b_data), 32'h04);
      checkOutput("t2_cnt_b",  32'(cnt_b),  32'd4);

      // Alternating mode, in_sel held at 1 to show it is ignored
      for (int i = 0; i < 6; i++) begin
         applyStimulus(i < 5, 8'(8'hA0 + i), 1, 1, 1, 1);
         #1;
         if (i > 0) begin
            if (((i - 1) % 2) == 0)
               checkOutput("t4_a_data", 32'(a_data), 32'(8'hA0 + i - 1));
            else
               checkOutput("t4_b_data", 32'(b_data), 32'(8'hA0 + i - 1));
         end
      end
      applyStimulus(0, 8'h00, 0, 0, 1, 1);
      applyStimulus(1, 8'hB0, 1, 1, 1, 1);
      applyStimulus(0, 8'h00, 1, 1, 1, 1);
      #1;
      checkOutput("t4_resume_a_valid", 32'(a_valid), 32'd1);
      checkOutput("t4_resume_a_data",  32'(a_data),  32'hB0);

      // Counter saturation
      doReset();
      for (int i = 0; i < 11; i++) begin
         applyStimulus(i < 10, 8'(8'h80 + i), 0, 0, 1, 1);
         #1;
         if (i > 0) checkOutput("t5_cnt_a", 32'(cnt_a), 32'((i < CNT_MAX) ? i : CNT_MAX));
      end

      // Both ports full with pointer at B, then reset mid-operation
      applyStimulus(1, 8'h30, 0, 1, 1, 0);
      applyStimulus(1, 8'h31, 0, 1, 1, 0);
      applyStimulus(1, 8'h32, 0, 1, 0, 0);
      applyStimulus(0, 8'h00, 0, 1, 0, 0);
      doReset();
      applyStimulus(1, 8'h55, 1, 1, 0, 0);
      applyStimulus(0, 8'h00, 1, 1, 0, 0);
      #1;
      checkOutput("t6_ptr_a_valid", 32'(a_valid), 32'd1);
      checkOutput("t6_ptr_a_data",  32'(a_data),  32'h55);
      checkOutput("t6_ptr_b_valid", 32'(b_valid), 32'd0);

      // Randomized traffic
      altCur = 1'b0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc == 2000) doReset();
         if (!mStalled && $urandom_range(0, 19) == 0) altCur = !altCur;
         applyStimulus($urandom_range(0, 99) < 70, 8'($urandom), 1'($urandom),
                       altCur, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60);
      end
      applyStimulus(0, 8'h00, 0, altCur, 1, 1);
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stream_demux2.md
Name: stream_demux2

Overview:
- Registered 1-to-2 stream demultiplexer. It is the receive-side counterpart of the two-way mux.
- Routes each word on a single valid/ready input stream to output A or output B.
- Each output has a one-entry holding register, so a stalled port does not block traffic already buffered on the other port.
- Sits between the operand/result bus and the two ALU-side consumers. Selection convention matches the mux: select 0 goes to A, select 1 goes to B.

Parameters:
- WIDTH, 8, data word width in bits.
- CNT_W, 8, width of the per-port transfer counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_sel  input  1  destination: 0 routes to A, 1 routes to B. Ignored when alt_mode=1.
- in_valid  input  1  in_data/in_sel are valid.
- in_ready  output  1  block accepts the word this cycle.
- alt_mode  input  1  1 means alternate A,B,A,B... using an internal pointer.
- a_data  output  WIDTH  port A word.
- a_valid  output  1  port A holding register full.
- a_ready  input  1  port A consumer accepts.
- b_data  output  WIDTH  port B word.
- b_valid  output  1  port B holding register full.
- b_ready  input  1  port B consumer accepts.
- cnt_a  output  CNT_W  words accepted for A. Saturating.
- cnt_b  output  CNT_W  words accepted for B. Saturating.

Behaviour:
- Reset (async assert; internal registers clear; synchronous deassert handled outside the block):
  - a_valid=0, b_valid=0, a_data=0, b_data=0.
  - cnt_a=0, cnt_b=0, alt pointer=0.
  - Reset mid-operation discards any buffered words.
- Destination: dest = alt_mode ? ptr : in_sel.
- in_ready (combinational):
  - dest=A: in_ready = !a_valid | a_ready.
  - dest=B: in_ready = !b_valid | b_ready.
  - in_ready depends on in_sel/alt_mode, not on in_valid.
- Accept: a transfer occurs when in_valid & in_ready at a rising edge. On accept, the destination register loads in_data and its valid is set.
- Latency: exactly 1 cycle. A word accepted at edge N is on x_data with x_valid=1 after edge N.
- Drain: x_valid & x_ready at an edge clears x_valid, unless the same edge loads a new word into that port.
- Simultaneous drain and load on the same port: the new word replaces the old one and x_valid stays 1. Full throughput is one word per cycle per port.
- Head-of-line blocking: if the destination port is full and not draining, in_ready=0 even when the other port is empty. No reordering and no bypass.
- Port independence: A and B drain independently. The non-destination port may drain in the same cycle as an accept.
- x_data holds its value while x_valid=1 and x_ready=0. It is unchanged after a drain until the next load.
- Alt pointer:
  - Toggles on every accepted transfer while alt_mode=1.
  - Forced to 0 on any edge where alt_mode=0, so re-entering alt mode always starts at A.
  - alt_mode is sampled per cycle. The block assumes the producer does not change it while in_valid=1 and in_ready=0.
- Counters:
  - cnt_a increments on each accept with dest=A; cnt_b on each accept with dest=B.
  - Each saturates at 2^CNT_W-1; no wrap.
- Back-pressure invariants:
  - No word is ever lost or duplicated.
  - A word accepted for A never appears on B, and vice versa.

Test Plan:
- Reset, then sel=0, data 0x5A, a_ready=0 -> a_valid=1, a_data=0x5A one cycle later; b_valid=0; cnt_a=1; the next sel=0 word sees in_ready=0.
- Sel=1 stream 0x01..0x04, b_ready=1 continuously -> in_ready held at 1; B emits 0x01..0x04 on consecutive cycles with 1-cycle latency; cnt_b=4.
- A full and stalled (0x11 held), then in_sel=1 word 0x22 -> accepted to B the same cycle; a_data stays 0x11 until a_ready=1.
- alt_mode=1, words 0xA0,0xA1,0xA2,0xA3, both readies 1 -> A receives 0xA0,0xA2; B receives 0xA1,0xA3. Drop alt_mode for one cycle, then resume -> next word goes to A.
- CNT_W=2, five words to A with a_ready=1 -> cnt_a reads 1,2,3,3,3.
- Assert rst while both ports hold data with readies low -> a_valid, b_valid, counters and pointer are 0 immediately (asynchronously); no old data appears after release.
